instr_align_decompress: RTL and testbench
=========================================

# instr_align_decompress

Fetch-side instruction aligner and RVC expander between the instruction bus and decode. Buffers 32-bit fetch words as halfwords, reassembles 32-bit instructions that straddle word boundaries, expands 16-bit instructions through `instr_decompress`, and presents one 32-bit instruction plus its PC per valid/ready handshake. Also handles jump redirects, including targets on a halfword boundary.

## Interface
Parameters:
- `PASSTHROUGH`, 0: 1 = no RVC support; every instruction is treated as 32-bit and word-aligned.
- `DEPTH`, 2: buffer capacity in 32-bit words (holds 2*DEPTH halfwords); must be at least 2.
- `W_ADDR`, 32: PC width.
- `RESET_VECTOR`, 0: PC after reset; bit 0 must be 0.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `fetch_valid`  in  1  fetch word available.
- `fetch_ready`  out  1  buffer accepts a word this cycle.
- `fetch_data`  in  32  fetched word, little-endian halfwords.
- `jump_valid`  in  1  redirect/flush request.
- `jump_target`  in  W_ADDR  redirect PC; bit 0 ignored.
- `instr_valid`  out  1  complete instruction at buffer head.
- `instr_ready`  in  1  decode consumes the head instruction.
- `instr_data`  out  32  expanded 32-bit instruction.
- `instr_pc`  out  W_ADDR  PC of the head instruction.
- `instr_is_32bit`  out  1  head instruction was 32-bit (PC step 4), else 16-bit (PC step 2).
- `instr_invalid`  out  1  head is illegal or reserved per `instr_decompress`.

## Operation
- State:
  - halfword buffer `hw[0..2*DEPTH-1]`;
  - `level` (0..2*DEPTH);
  - `pc`;
  - `skip_lo` flag.
- Head classification:
  - If `level>=1` and `hw[0][1:0]!=2'b11`: 16-bit instruction, valid.
  - If `hw[0][1:0]==2'b11`: needs `level>=2`; instruction is `{hw[1],hw[0]}`.
  - If `PASSTHROUGH`: always 32-bit, needs `level>=2`.
- `instr_valid` follows the head classification above; `instr_data`, `instr_is_32bit` and `instr_invalid` come combinationally from `instr_decompress` applied to `{hw[1],hw[0]}`.
- Outputs are don't-care when `instr_valid`=0. The bench checks them only when valid.
- Consume on `instr_valid && instr_ready`:
  - shift out 1 or 2 halfwords;
  - `pc <= pc + 2` or `pc + 4`, modulo 2^W_ADDR (all-ones wraps to 0).
- Accept on `fetch_valid && fetch_ready`:
  - append 2 halfwords at position `level` minus the consumed count;
  - if `skip_lo`, append only the upper halfword, then clear `skip_lo`.
- `fetch_ready = (level - consumed) <= 2*DEPTH-2`. This is combinational on `instr_ready`, so a full buffer drained in the same cycle accepts a word.
- A consume and an accept in the same cycle are both performed.
- Jump (highest priority):
  - `level <= 0`;
  - `pc <= {jump_target[W_ADDR-1:1],1'b0}`;
  - `skip_lo <= jump_target[1]`.
  - Any fetch handshake or consume in the same cycle is discarded. `instr_ready` is ignored and `pc` does not step.
  - The first word fetched after the jump is the word containing the target.
- Illegal instructions are delivered with `instr_invalid`=1 (e.g. `16'h0000`, reserved `c.lui`/`c.addi16sp` with zero immediate, `c.lwsp` with rd=0, `c.jr` with rs1=0, `c.ebreak`). Trap handling belongs to decode.

## Timing
- Reset values:
  - `level`=0, `pc`=RESET_VECTOR, `skip_lo`=0;
  - `instr_valid`=0, `fetch_ready`=1;
  - `instr_pc`=RESET_VECTOR;
  - `instr_data`, `instr_is_32bit`, `instr_invalid` don't-care.
- Reset mid-stream drops all buffered halfwords.
- Latency: a word accepted at edge N is visible on the `instr_*` outputs after edge N, i.e. during cycle N+1.
- Throughput: sustains one instruction per cycle whenever fetch supplies one word per cycle.
- A straddling 32-bit instruction waits for its second word and never stalls a 16-bit instruction already at the head.
- `instr_valid` must not depend on `instr_ready`.
- Once asserted, `instr_valid` stays high with stable `instr_data` and `instr_pc` until it is consumed or a jump occurs.
- `fetch_ready` may depend on `instr_ready`. `fetch_ready` must not depend on `fetch_valid`.

## Structure
- Shared package (`definitions.v` / `compress_instr.v`) holds:
  - the existing `RV_C_*` / `RV_NOZ_*` encodings;
  - new `W_HALF`=16 and the opcode-size mask `RV_OP_32BIT`=2'b11.
- One sub-module: the existing `instr_decompress` (its `PASSTHROUGH` tied to this block's `PASSTHROUGH`).
- The buffer, level counter, PC and skip logic live in this module.

## Test plan
- Reset then fetch `32'h00130113`, ready=1 → one cycle later: `instr_data`=`32'h00130113`, `instr_pc`=0, `instr_is_32bit`=1.
- Fetch `32'h4501_0505` (c.addi a0,1 ; c.li a0,0) → two instructions:
  - `32'h00150513` at pc 0;
  - `32'h00000513` at pc 2.
- Straddle:
  - fetch `32'h0113_0505`, then `32'h????_0013`;
  - → `32'h00150513` at pc 0;
  - `instr_valid` low until the second word arrives;
  - then `32'h00130113` at pc 2; next pc is 6.
- Jump to `0x102`, next fetch `32'h0505_xxxx` → lower halfword dropped; `32'h00150513` at `instr_pc`=`0x102`.
- Hold `instr_ready`=0 with 2*DEPTH halfwords buffered → `fetch_ready`=0 and outputs stable. Raise `instr_ready` with 32-bit heads → `fetch_ready`=1 in the same cycle.
- Fetch `32'h0000_0000` → `instr_invalid`=1, `instr_is_32bit`=0. Also: `pc` at all-ones-minus-1 plus c.nop → pc wraps to 0.

Source files
------------

// File: rtl/instr_align_decompress_pkg.sv
// rtl/instr_align_decompress_pkg.sv - RVC encodings, 32-bit opcodes and aligner constants
package instr_align_decompress_pkg;

   localparam int         W_HALF      = 16;
   localparam logic [1:0] RV_OP_32BIT = 2'b11;

   typedef enum logic [1:0] {
      RV_C_Q0 = 2'b00,
      RV_C_Q1 = 2'b01,
      RV_C_Q2 = 2'b10,
      RV_C_Q3 = 2'b11
   } rv_c_quadrant_e;

   localparam logic [2:0] RV_C_ADDI4SPN = 3'b000;
   localparam logic [2:0] RV_C_LW       = 3'b010;
   localparam logic [2:0] RV_C_SW       = 3'b110;
   localparam logic [2:0] RV_C_ADDI     = 3'b000;
   localparam logic [2:0] RV_C_JAL      = 3'b001;
   localparam logic [2:0] RV_C_LI       = 3'b010;
   localparam logic [2:0] RV_C_LUI      = 3'b011;
   localparam logic [2:0] RV_C_MISC_ALU = 3'b100;
   localparam logic [2:0] RV_C_J        = 3'b101;
   localparam logic [2:0] RV_C_BEQZ     = 3'b110;
   localparam logic [2:0] RV_C_BNEZ     = 3'b111;
   localparam logic [2:0] RV_C_SLLI     = 3'b000;
   localparam logic [2:0] RV_C_LWSP     = 3'b010;
   localparam logic [2:0] RV_C_JR_ADD   = 3'b100;
   localparam logic [2:0] RV_C_SWSP     = 3'b110;

   localparam logic [6:0]  RV_NOZ_OP_IMM = 7'b0010011;
   localparam logic [6:0]  RV_NOZ_OP     = 7'b0110011;
   localparam logic [6:0]  RV_NOZ_LUI    = 7'b0110111;
   localparam logic [6:0]  RV_NOZ_LOAD   = 7'b0000011;
   localparam logic [6:0]  RV_NOZ_STORE  = 7'b0100011;
   localparam logic [6:0]  RV_NOZ_BRANCH = 7'b1100011;
   localparam logic [6:0]  RV_NOZ_JAL    = 7'b1101111;
   localparam logic [6:0]  RV_NOZ_JALR   = 7'b1100111;
   localparam logic [31:0] RV_NOZ_EBREAK = 32'h0010_0073;

   // Compressed 3-bit register fields address x8..x15.
   function automatic logic [4:0] rvc_reg(input logic [2:0] r);
      return {2'b01, r};
   endfunction

endpackage

// File: rtl/instr_decompress.sv
// rtl/instr_decompress.sv - RV32C to RV32I expander; flags illegal/reserved encodings
module instr_decompress
   import instr_align_decompress_pkg::*;
#(
   parameter bit PASSTHROUGH = 1'b0
) (
   input  logic [31:0] instr_raw,
   output logic [31:0] instr_data,
   output logic        is_32bit,
   output logic        invalid
);

   logic [15:0] c;
   logic [4:0]  rd;
   logic [4:0]  rs2;
   logic [4:0]  rdp;
   logic [4:0]  rs2p;

   assign c    = instr_raw[15:0];
   assign rd   = c[11:7];
   assign rs2  = c[6:2];
   assign rdp  = rvc_reg(c[9:7]);
   assign rs2p = rvc_reg(c[4:2]);

   always_comb begin
      instr_data = instr_raw;
      is_32bit   = 1'b1;
      invalid    = 1'b0;
      if (!PASSTHROUGH && instr_raw[1:0] != RV_OP_32BIT) begin
         is_32bit   = 1'b0;
         instr_data = {16'h0000, c};
         case (rv_c_quadrant_e'(c[1:0]))
            RV_C_Q0: begin
               case (c[15:13])
                  RV_C_ADDI4SPN: begin
                     instr_data = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rs2p, RV_NOZ_OP_IMM};
                     invalid    = (c[12:5] == 8'h00);
                  end
                  RV_C_LW:
                     instr_data = {5'b0, c[5], c[12:10], c[6], 2'b00, rdp, 3'b010, rs2p, RV_NOZ_LOAD};
                  RV_C_SW:
                     instr_data = {5'b0, c[5], c[12], rs2p, rdp, 3'b010, c[11:10], c[6], 2'b00, RV_NOZ_STORE};
                  default: invalid = 1'b1;
               endcase
            end
            RV_C_Q1: begin
               case (c[15:13])
                  RV_C_ADDI:
                     instr_data = {{7{c[12]}}, c[6:2], rd, 3'b000, rd, RV_NOZ_OP_IMM};
                  RV_C_JAL, RV_C_J:
                     instr_data = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12], {8{c[12]}},
                                   4'b0000, ~c[15], RV_NOZ_JAL};
                  RV_C_LI:
                     instr_data = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, rd, RV_NOZ_OP_IMM};
                  RV_C_LUI: begin
                     invalid = ({c[12], c[6:2]} == 6'd0);
                     if (rd == 5'd2)
                        instr_data = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, RV_NOZ_OP_IMM};
                     else
                        instr_data = {{15{c[12]}}, c[6:2], rd, RV_NOZ_LUI};
                  end
                  RV_C_MISC_ALU: begin
                     case (c[11:10])
                        2'b00, 2'b01: begin
                           instr_data = {1'b0, c[10], 5'b0, c[6:2], rdp, 3'b101, rdp, RV_NOZ_OP_IMM};
                           invalid    = c[12];
                        end
                        2'b10:
                           instr_data = {{7{c[12]}}, c[6:2], rdp, 3'b111, rdp, RV_NOZ_OP_IMM};
                        default: begin
                           invalid = c[12];
                           case (c[6:5])
                              2'b00:   instr_data = {7'b0100000, rs2p, rdp, 3'b000, rdp, RV_NOZ_OP};
                              2'b01:   instr_data = {7'b0000000, rs2p, rdp, 3'b100, rdp, RV_NOZ_OP};
                              2'b10:   instr_data = {7'b0000000, rs2p, rdp, 3'b110, rdp, RV_NOZ_OP};
                              default: instr_data = {7'b0000000, rs2p, rdp, 3'b111, rdp, RV_NOZ_OP};
                           endcase
                        end
                     endcase
                  end
                  default:
                     instr_data = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rdp, 2'b00, c[13], c[11:10], c[4:3],
                                   c[12], RV_NOZ_BRANCH};
               endcase
            end
            RV_C_Q2: begin
               case (c[15:13])
                  RV_C_SLLI: begin
                     instr_data = {7'b0, c[6:2], rd, 3'b001, rd, RV_NOZ_OP_IMM};
                     invalid    = c[12];
                  end
                  RV_C_LWSP: begin
                     instr_data = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, RV_NOZ_LOAD};
                     invalid    = (rd == 5'd0);
                  end
                  RV_C_JR_ADD: begin
                     if (rs2 != 5'd0)
                        instr_data = {7'b0, rs2, (c[12] ? rd : 5'd0), 3'b000, rd, RV_NOZ_OP};
                     else if (rd == 5'd0) begin
                        // c.ebreak is expanded but still flagged so decode raises the trap.
                        instr_data = RV_NOZ_EBREAK;
                        invalid    = 1'b1;
                     end else
                        instr_data = {12'b0, rd, 3'b000, 4'b0000, c[12], RV_NOZ_JALR};
                  end
                  RV_C_SWSP:
                     instr_data = {4'b0, c[8:7], c[12], c[6:2], 5'd2, 3'b010, c[11:9], 2'b00, RV_NOZ_STORE};
                  default: invalid = 1'b1;
               endcase
            end
            default: invalid = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/instr_align_decompress.sv
// rtl/instr_align_decompress.sv - halfword fetch buffer, instruction alignment, RVC expansion and PC tracking
module instr_align_decompress
   import instr_align_decompress_pkg::*;
#(
   parameter bit                PASSTHROUGH  = 1'b0,
   parameter int                DEPTH        = 2,
   parameter int                W_ADDR       = 32,
   parameter logic [W_ADDR-1:0] RESET_VECTOR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_valid,
   output logic              fetch_ready,
   input  logic [31:0]       fetch_data,
   input  logic              jump_valid,
   input  logic [W_ADDR-1:0] jump_target,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instr_data,
   output logic [W_ADDR-1:0] instr_pc,
   output logic              instr_is_32bit,
   output logic              instr_invalid
);

   localparam int N_HW  = 2 * DEPTH;
   localparam int W_LVL = $clog2(N_HW + 1);

   logic [W_HALF-1:0]      hw      [N_HW];
   logic [W_HALF-1:0]      hw_next [N_HW];
   logic [N_HW*W_HALF-1:0] flat;
   logic [N_HW*W_HALF-1:0] shifted;
   logic [W_LVL-1:0]       level;
   logic [W_LVL-1:0]       level_next;
   logic [W_LVL-1:0]       consumed;
   logic [W_LVL-1:0]       remain;
   logic [W_ADDR-1:0]      pc;
   logic                   skip_lo;
   logic                   take;
   logic                   accept;
   logic                   unused_target_lsb;

   assign unused_target_lsb = jump_target[0];

   instr_decompress #(.PASSTHROUGH(PASSTHROUGH)) u_decompress (
      .instr_raw  ({hw[1], hw[0]}),
      .instr_data (instr_data),
      .is_32bit   (instr_is_32bit),
      .invalid    (instr_invalid)
   );

   assign instr_valid = instr_is_32bit ? (level >= W_LVL'(2)) : (level >= W_LVL'(1));
   assign instr_pc    = pc;
   assign take        = instr_valid && instr_ready;
   assign consumed    = take ? (instr_is_32bit ? W_LVL'(2) : W_LVL'(1)) : '0;
   assign remain      = level - consumed;
   assign fetch_ready = (remain <= W_LVL'(N_HW - 2));
   assign accept      = fetch_valid && fetch_ready;

   // Shift out consumed halfwords, then drop the new word in right behind what remains.
   always_comb begin
      for (int i = 0; i < N_HW; i++)
         flat[i*W_HALF +: W_HALF] = hw[i];
      shifted    = flat >> (W_HALF * consumed);
      level_next = remain;
      for (int i = 0; i < N_HW; i++) begin
         hw_next[i] = shifted[i*W_HALF +: W_HALF];
         if (accept) begin
            if (skip_lo) begin
               if (W_LVL'(i) == remain)
                  hw_next[i] = fetch_data[31:16];
            end else begin
               if (W_LVL'(i) == remain)
                  hw_next[i] = fetch_data[15:0];
               if (W_LVL'(i) == remain + W_LVL'(1))
                  hw_next[i] = fetch_data[31:16];
            end
         end
      end
      if (accept)
         level_next = remain + (skip_lo ? W_LVL'(1) : W_LVL'(2));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         level   <= '0;
         pc      <= RESET_VECTOR;
         skip_lo <= 1'b0;
      end else if (jump_valid) begin
         level   <= '0;
         pc      <= {jump_target[W_ADDR-1:1], 1'b0};
         skip_lo <= PASSTHROUGH ? 1'b0 : jump_target[1];
      end else begin
         level <= level_next;
         if (accept)
            skip_lo <= 1'b0;
         if (take)
            pc <= pc + (instr_is_32bit ? W_ADDR'(4) : W_ADDR'(2));
      end
   end

   // Contents beyond level are never observed, so the data array needs no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_HW; i++)
         hw[i] <= hw_next[i];
   end

endmodule

// File: tb/tb_instr_align_decompress.sv
// tb/tb_instr_align_decompress.sv - directed scoreboard bench for instr_align_decompress
module tb_instr_align_decompress;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_data;
   logic        jump_valid;
   logic [31:0] jump_target;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
   logic        instr_is_32bit;
   logic        instr_invalid;

   int checks = 0;
   int passed = 0;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] pc;
      logic        is32;
      logic        inv;
      logic        chk_data;
   } exp_t;

   exp_t sb[$];

   logic [15:0] hw_tab  [12] = '{16'h4512, 16'h952E, 16'h852E, 16'h8082, 16'h4012, 16'h8002,
                                 16'h9002, 16'h6501, 16'h6101, 16'h6505, 16'h8C05, 16'hE401};
   logic [31:0] exp_tab [12] = '{32'h00412503, 32'h00B50533, 32'h00B00533, 32'h00008067, 32'h0, 32'h0,
                                 32'h0, 32'h0, 32'h0, 32'h00001537, 32'h40940433, 32'h00041463};
   logic        inv_tab [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

   always #5 clk = ~clk;

   instr_align_decompress dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_valid    (fetch_valid),
      .fetch_ready    (fetch_ready),
      .fetch_data     (fetch_data),
      .jump_valid     (jump_valid),
      .jump_target    (jump_target),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc),
      .instr_is_32bit (instr_is_32bit),
      .instr_invalid  (instr_invalid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic push(input logic [31:0] d, input logic [31:0] p, input logic is32, input logic inv,
                       input logic chk_data);
      exp_t e;
      e.data     = d;
      e.pc       = p;
      e.is32     = is32;
      e.inv      = inv;
      e.chk_data = chk_data;
      sb.push_back(e);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!instr_valid && n < 20) begin
         tick();
         n++;
      end
      check("instr_valid_wait", {31'b0, instr_valid}, 32'd1);
   endtask

   task automatic check_head();
      exp_t e;
      check("scoreboard_nonempty", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         if (e.chk_data)
            check($sformatf("instr_data@%h", e.pc), instr_data, e.data);
         check("instr_pc", instr_pc, e.pc);
         check($sformatf("instr_is_32bit@%h", e.pc), {31'b0, instr_is_32bit}, {31'b0, e.is32});
         check($sformatf("instr_invalid@%h", e.pc), {31'b0, instr_invalid}, {31'b0, e.inv});
      end
   endtask

   task automatic consume();
      wait_valid();
      check_head();
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] w);
      int n = 0;
      fetch_valid = 1'b1;
      fetch_data  = w;
      while (!fetch_ready && n < 20) begin
         tick();
         n++;
      end
      check("fetch_ready_wait", {31'b0, fetch_ready}, 32'd1);
      tick();
      fetch_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      fetch_valid = 1'b0;
      instr_ready = 1'b0;
      jump_valid  = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic jump(input logic [31:0] t);
      jump_valid  = 1'b1;
      jump_target = t;
      tick();
      jump_valid = 1'b0;
   endtask

   initial begin
      fetch_data  = '0;
      jump_target = '0;
      do_reset();
      check("reset_instr_valid", {31'b0, instr_valid}, 32'd0);
      check("reset_fetch_ready", {31'b0, fetch_ready}, 32'd1);
      check("reset_instr_pc", instr_pc, 32'h0);

      // single 32-bit word, visible the cycle after the accepting edge
      push(32'h00130113, 32'h0, 1'b1, 1'b0, 1'b1);
      fetch(32'h00130113);
      check("latency_valid", {31'b0, instr_valid}, 32'd1);
      consume();

      // reset mid-stream drops buffered halfwords
      fetch(32'h00230213);
      do_reset();
      check("midreset_valid", {31'b0, instr_valid}, 32'd0);
      check("midreset_pc", instr_pc, 32'h0);

      // two compressed instructions in one word
      push(32'h00150513, 32'h0, 1'b0, 1'b0, 1'b1);
      push(32'h00000513, 32'h2, 1'b0, 1'b0, 1'b1);
      fetch(32'h4501_0505);
      consume();
      consume();

      // straddling 32-bit instruction
      do_reset();
      push(32'h00150513, 32'h0, 1'b0, 1'b0, 1'b1);
      fetch(32'h0113_0505);
      consume();
      check("straddle_wait_valid", {31'b0, instr_valid}, 32'd0);
      tick();
      check("straddle_wait_valid2", {31'b0, instr_valid}, 32'd0);
      push(32'h00130113, 32'h2, 1'b1, 1'b0, 1'b1);
      fetch(32'h0000_0013);
      consume();
      check("straddle_next_pc", instr_pc, 32'h6);
      push(32'h0, 32'h6, 1'b0, 1'b1, 1'b0);
      consume();

      // jump to a halfword-aligned target drops the low halfword
      jump(32'h0000_0102);
      check("jump_valid_low", {31'b0, instr_valid}, 32'd0);
      check("jump_pc", instr_pc, 32'h102);
      push(32'h00150513, 32'h102, 1'b0, 1'b0, 1'b1);
      fetch(32'h0505_1234);
      consume();

      // full buffer backpressure, then drain and refill in one cycle
      do_reset();
      push(32'h00130113, 32'h0, 1'b1, 1'b0, 1'b1);
      push(32'h00230213, 32'h4, 1'b1, 1'b0, 1'b1);
      push(32'h00330313, 32'h8, 1'b1, 1'b0, 1'b1);
      fetch(32'h00130113);
      fetch(32'h00230213);
      fetch_valid = 1'b1;
      fetch_data  = 32'h00330313;
      for (int k = 0; k < 3; k++) begin
         check("full_fetch_ready", {31'b0, fetch_ready}, 32'd0);
         check("full_hold_valid", {31'b0, instr_valid}, 32'd1);
         check("full_hold_data", instr_data, 32'h00130113);
         check("full_hold_pc", instr_pc, 32'h0);
         tick();
      end
      check_head();
      instr_ready = 1'b1;
      #1;
      check("drain_fetch_ready", {31'b0, fetch_ready}, 32'd1);
      tick();
      instr_ready = 1'b0;
      fetch_valid = 1'b0;
      consume();
      consume();

      // illegal all-zero halfwords
      do_reset();
      push(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      push(32'h0, 32'h2, 1'b0, 1'b1, 1'b0);
      fetch(32'h0000_0000);
      consume();
      consume();

      // expansion table, two halfwords per fetch word
      jump(32'h0000_0200);
      for (int i = 0; i < 6; i++) begin
         push(exp_tab[2*i],   32'h200 + 32'(4*i),     1'b0, inv_tab[2*i],   !inv_tab[2*i]);
         push(exp_tab[2*i+1], 32'h200 + 32'(4*i + 2), 1'b0, inv_tab[2*i+1], !inv_tab[2*i+1]);
         fetch({hw_tab[2*i+1], hw_tab[2*i]});
         consume();
         consume();
      end

      // pc wraps from all-ones-minus-one to zero
      jump(32'hFFFF_FFFE);
      push(32'h00000013, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
      fetch(32'h0001_5555);
      consume();
      check("wrap_pc", instr_pc, 32'h0);
      check("scoreboard_drained", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
